// File: rtl/tft_spi_tx.sv
// tft_spi_tx: byte-wide SPI mode-0 transmitter for TFT panels with D/C and lazy chip-select release.
// Optional TFT_SPI_HWRESET_EN adds a panel hardware-reset sequence on tft_rst_n.
module tft_spi_tx #(
   parameter int CLK_DIV  = 2,
   parameter int CS_IDLE  = 16,
   parameter int RST_LOW  = 1000,
   parameter int RST_WAIT = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tft_transmit,
   input  logic       tft_dc,
   input  logic [7:0] tft_data,
   output logic       tft_busy,
   output logic       spi_sclk,
   output logic       spi_mosi,
   output logic       spi_cs_n,
   output logic       spi_dc
`ifdef TFT_SPI_HWRESET_EN
   ,
   output logic       tft_rst_n
`endif
);
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int IW = CS_IDLE > 1 ? $clog2(CS_IDLE) : 1;
   if (CLK_DIV < 1 || CLK_DIV > 255 || CS_IDLE < 1 || CS_IDLE > 65535 || RST_LOW < 1 || RST_WAIT < 1)
   begin : g_bad_param
      $error("tft_spi_tx: parameter out of range");
   end
`ifdef TFT_SPI_HWRESET_EN
   localparam int RM = RST_LOW > RST_WAIT ? RST_LOW : RST_WAIT;
   localparam int RW = RM > 1 ? $clog2(RM) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, RSTLO, RSTWAIT} state_t;
   localparam state_t S_RST = RSTLO;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          rst_n_q, rst_n_d;
   assign tft_rst_n = rst_n_q;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
   localparam state_t S_RST = IDLE;
`endif
   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [3:0]    tog_q, tog_d;
   logic [7:0]    sh_q, sh_d;
   logic [IW-1:0] idle_q, idle_d;
   logic          sclk_q, sclk_d, cs_n_q, cs_n_d, dc_q, dc_d;
   assign tft_busy = state_q != IDLE;
   assign spi_sclk = sclk_q;
   assign spi_mosi = sh_q[7];
   assign spi_cs_n = cs_n_q;
   assign spi_dc   = dc_q;
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      tog_d   = tog_q;
      sh_d    = sh_q;
      idle_d  = idle_q;
      sclk_d  = sclk_q;
      cs_n_d  = cs_n_q;
      dc_d    = dc_q;
`ifdef TFT_SPI_HWRESET_EN
      rcnt_d  = rcnt_q;
      rst_n_d = rst_n_q;
`endif
      case (state_q)
         IDLE: begin
            if (tft_transmit) begin
               state_d = SHIFT;
               sh_d    = tft_data;
               dc_d    = tft_dc;
               cs_n_d  = 1'b0;
               sclk_d  = 1'b0;
               div_d   = '0;
               tog_d   = '0;
               idle_d  = '0;
            end else if (!cs_n_q) begin
               cs_n_d = idle_q == IW'(CS_IDLE - 1);
               idle_d = cs_n_d ? '0 : idle_q + 1'b1;
            end
         end
         SHIFT: begin
            if (div_q == DW'(CLK_DIV - 1)) begin
               div_d  = '0;
               sclk_d = !sclk_q;
               tog_d  = tog_q + 1'b1;
               // the final falling edge ends the byte; bit 0 stays on mosi
               sh_d    = (sclk_q && tog_q != 4'd15) ? {sh_q[6:0], 1'b0} : sh_q;
               state_d = tog_q == 4'd15 ? IDLE : SHIFT;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
`ifdef TFT_SPI_HWRESET_EN
         RSTLO: begin
            rcnt_d  = rcnt_q == RW'(RST_LOW - 1) ? '0 : rcnt_q + 1'b1;
            rst_n_d = rcnt_q == RW'(RST_LOW - 1);
            state_d = rst_n_d ? RSTWAIT : RSTLO;
         end
         RSTWAIT: begin
            rcnt_d  = rcnt_q == RW'(RST_WAIT - 1) ? '0 : rcnt_q + 1'b1;
            state_d = rcnt_q == RW'(RST_WAIT - 1) ? IDLE : RSTWAIT;
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RST;
         div_q   <= '0;
         tog_q   <= '0;
         sh_q    <= '0;
         idle_q  <= '0;
         sclk_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         dc_q    <= 1'b0;
`ifdef TFT_SPI_HWRESET_EN
         rcnt_q  <= '0;
         rst_n_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         tog_q   <= tog_d;
         sh_q    <= sh_d;
         idle_q  <= idle_d;
         sclk_q  <= sclk_d;
         cs_n_q  <= cs_n_d;
         dc_q    <= dc_d;
`ifdef TFT_SPI_HWRESET_EN
         rcnt_q  <= rcnt_d;
         rst_n_q <= rst_n_d;
`endif
      end
   end
endmodule

// File: tb/tb_tft_spi_tx.sv
// tb_tft_spi_tx: timeline model of the byte transmitter checked every cycle, plus directed literal checks.
module tb_tft_spi_tx;
   localparam int D = 2;
   localparam int CSI = 16;
`ifdef TFT_SPI_HWRESET_EN
   localparam int RL = 10;
   localparam int HWC = 30;
`else
   localparam int HWC = 0;
`endif
   logic clk = 0, rst = 1, tr = 0, dc = 0, tr1 = 0;
   logic [7:0] data = 8'h00, data1 = 8'h00;
   logic busy, sclk, mosi, cs_n, sdc;
   logic busy1, sclk1, mosi1, cs1, sdc1;
   int tests = 0, fails = 0;
   bit m_ok = 0, m_act = 0;
   int m_t = 0, m_idle = 0, m_hw = 0;
   logic [7:0] m_b = 0;
   logic m_dc = 0, m_cs = 1, m_last = 0;
   int rises = 0, busy_tot = 0, cs_hi = 0, rises1 = 0, acc1 = 0;
   logic [7:0] cap = 0, cap1 = 0;
   logic p_sclk = 0, p_sclk1 = 0, p_busy1 = 0;
`ifdef TFT_SPI_HWRESET_EN
   logic rst_n, rst_n1;
   tft_spi_tx #(.CLK_DIV(D), .CS_IDLE(CSI), .RST_LOW(RL), .RST_WAIT(HWC - RL)) dut (
      .clk(clk), .rst(rst), .tft_transmit(tr), .tft_dc(dc), .tft_data(data), .tft_busy(busy),
      .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n), .spi_dc(sdc), .tft_rst_n(rst_n));
   tft_spi_tx #(.CLK_DIV(1), .CS_IDLE(CSI), .RST_LOW(RL), .RST_WAIT(HWC - RL)) dut1 (
      .clk(clk), .rst(rst), .tft_transmit(tr1), .tft_dc(1'b0), .tft_data(data1), .tft_busy(busy1),
      .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_cs_n(cs1), .spi_dc(sdc1), .tft_rst_n(rst_n1));
`else
   tft_spi_tx #(.CLK_DIV(D), .CS_IDLE(CSI)) dut (
      .clk(clk), .rst(rst), .tft_transmit(tr), .tft_dc(dc), .tft_data(data), .tft_busy(busy),
      .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n), .spi_dc(sdc));
   tft_spi_tx #(.CLK_DIV(1), .CS_IDLE(CSI)) dut1 (
      .clk(clk), .rst(rst), .tft_transmit(tr1), .tft_dc(1'b0), .tft_data(data1), .tft_busy(busy1),
      .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_cs_n(cs1), .spi_dc(sdc1));
`endif
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // one clock: advance the model on the edge, then compare and capture 1 time unit later
   task automatic tick();
      int idx;
      @(posedge clk);
      if (rst) begin
         m_ok = 1; m_act = 0; m_t = 0; m_b = 0; m_dc = 0; m_cs = 1; m_last = 0; m_idle = 0; m_hw = HWC;
      end else if (m_hw > 0) begin
         m_hw--;
      end else if (m_act) begin
         m_t++;
         if (m_t == 16 * D) begin m_act = 0; m_last = m_b[0]; end
      end else if (tr) begin
         m_act = 1; m_t = 0; m_b = data; m_dc = dc; m_cs = 0; m_idle = 0;
      end else if (!m_cs) begin
         m_idle++;
         if (m_idle == CSI) begin m_cs = 1; m_idle = 0; end
      end
      #1;
      if (m_ok) begin
         idx = 7 - m_t / (2 * D);
         chk("busy", busy, m_act || m_hw > 0);
         chk("sclk", sclk, m_act ? (m_t / D) % 2 : 0);
         chk("mosi", mosi, m_act ? m_b[idx] : m_last);
         chk("cs_n", cs_n, m_cs);
         chk("dc", sdc, m_dc);
`ifdef TFT_SPI_HWRESET_EN
         chk("rst_n", rst_n, !rst && m_hw <= HWC - RL);
`endif
      end
      if (sclk && !p_sclk) begin rises++; cap = {cap[6:0], mosi}; end
      if (sclk1 && !p_sclk1) begin rises1++; cap1 = {cap1[6:0], mosi1}; end
      if (busy1 && !p_busy1) acc1++;
      busy_tot += busy ? 1 : 0;
      cs_hi += cs_n ? 1 : 0;
      p_sclk = sclk; p_sclk1 = sclk1; p_busy1 = busy1;
   endtask
   task automatic send(input logic d, input logic [7:0] b);
      tr = 1; dc = d; data = b;
      tick();
      tr = 0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 400) begin tick(); n++; end
      chk("idle_timeout", busy, 0);
   endtask
   task automatic do_reset();
      rst = 1;
      tick();
      tick();
      rst = 0;
`ifdef TFT_SPI_HWRESET_EN
      begin
         int n = 0, lo = (rst_n == 0) ? 1 : 0;
         while (busy && n < 100) begin
            tr = n < 25;
            tick();
            n++;
            lo += (rst_n == 0) ? 1 : 0;
         end
         tr = 0;
         chk("hw_busy_cycles", n, HWC);
         chk("hw_rst_n_low", lo, RL);
      end
`endif
   endtask
   initial begin
      int r0, b0, c0, n;
      do_reset();
      rst = 1;
      tick();
      chk("rst_sclk", sclk, 0);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_mosi", mosi, 0);
      chk("rst_dc", sdc, 0);
      chk("rst_busy", busy, HWC > 0);
      do_reset();
      // single command byte 0x2A
      r0 = rises; b0 = busy_tot;
      send(0, 8'h2A);
      wait_idle();
      chk("b2a_bits", cap, 8'h2A);
      chk("b2a_rises", rises - r0, 8);
      chk("b2a_busy_cycles", busy_tot - b0, 32);
      chk("b2a_dc", sdc, 0);
      // back-to-back 0x2C (cmd) then 0xA5 (data), second request right after busy falls
      repeat (20) tick();
      r0 = rises; c0 = cs_hi;
      send(0, 8'h2C);
      wait_idle();
      chk("b2c_bits", cap, 8'h2C);
      chk("b2c_dc", sdc, 0);
      send(1, 8'hA5);
      chk("ba5_dc", sdc, 1);
      wait_idle();
      chk("ba5_bits", cap, 8'hA5);
      chk("b2b_rises", rises - r0, 16);
      chk("b2b_cs_low", cs_hi - c0, 0);
      // cs_n released exactly CSI cycles after busy falls
      n = 0;
      while (cs_n == 0 && n < 100) begin tick(); n++; end
      chk("cs_release_delay", n, CSI);
      // a request on the release cycle keeps cs_n low
      send(0, 8'h11);
      wait_idle();
      repeat (CSI - 1) tick();
      c0 = cs_hi;
      send(1, 8'h3C);
      chk("race_cs_n", cs_n, 0);
      chk("race_busy", busy, 1);
      wait_idle();
      chk("race_cs_hi", cs_hi - c0, 0);
      chk("race_bits", cap, 8'h3C);
      // reset mid-byte at the 4th rising edge
      repeat (CSI + 2) tick();
      r0 = rises;
      send(1, 8'h55);
      n = 0;
      while (rises - r0 < 4 && n < 100) begin tick(); n++; end
      chk("abort_rise4", rises - r0, 4);
      rst = 1;
      tick();
      chk("abort_sclk", sclk, 0);
      chk("abort_cs_n", cs_n, 1);
      chk("abort_busy", busy, HWC > 0);
      rst = 0;
      wait_idle();
      r0 = rises;
      send(0, 8'hFF);
      wait_idle();
      chk("ff_bits", cap, 8'hFF);
      chk("ff_rises", rises - r0, 8);
      // CLK_DIV=1 instance: request held for 40 cycles yields exactly 3 bytes
      r0 = rises1; b0 = acc1;
      tr1 = 1; data1 = 8'h81;
      repeat (40) tick();
      tr1 = 0;
      n = 0;
      while (busy1 && n < 100) begin tick(); n++; end
      chk("held_timeout", busy1, 0);
      chk("held_bytes", acc1 - b0, 3);
      chk("held_rises", rises1 - r0, 24);
      chk("held_bits", cap1, 8'h81);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
